// File: rtl/delay_timer_pkg.sv
// Shared types, default sizes and index helpers for the shared delay-timer arbiter.
package delay_timer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DELAY_W = 8;
  localparam int DEF_PTR_W   = $clog2(DEF_NUM_REQ);

  // Pointer width for a given requester count; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ... modulo NUM_REQ.
module rr_arbiter
  import delay_timer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = ptr_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_valid
);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [PTR_W:0]       off_s;
  logic [PTR_W:0]       sum_s;
  logic [PTR_W:0]       wrap_s;

  // Rotate requests so ptr sits at bit 0, take the lowest set offset, then un-rotate.
  always_comb begin
    dbl_s  = {req, req} >> ptr;
    rot_s  = dbl_s[NUM_REQ-1:0];
    off_s  = {(PTR_W+1){1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = (PTR_W+1)'(i);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, ptr} + off_s;
    if (sum_s >= (PTR_W+1)'(NUM_REQ)) begin
      wrap_s = sum_s - (PTR_W+1)'(NUM_REQ);
    end else begin
      wrap_s = sum_s;
    end
    win_idx   = wrap_s[PTR_W-1:0];
    win_valid = |req;
    if (win_valid) begin
      win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    end else begin
      win_onehot = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/delay_timer_arbiter.sv
// One countdown timer shared round-robin among NUM_REQ requesters; the owner gets a done pulse on expiry.
module delay_timer_arbiter
  import delay_timer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DELAY_W = DEF_DELAY_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DELAY_W-1:0] delay_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [DELAY_W-1:0]         count
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  state_t             state_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   owner_r;
  logic [PTR_W-1:0]   next_ptr_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic [NUM_REQ-1:0] win_onehot_s;
  logic               win_valid_s;
  logic               owner_req_s;
  logic [DELAY_W-1:0] win_delay_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req        (req),
    .ptr        (ptr_r),
    .win_onehot (win_onehot_s),
    .win_idx    (win_idx_s),
    .win_valid  (win_valid_s)
  );

  // Owner still requesting, pointer just past the owner, and the winner's delay slice.
  always_comb begin
    owner_req_s = |(req & grant);
    if (owner_r == PTR_W'(NUM_REQ - 1)) begin
      next_ptr_s = {PTR_W{1'b0}};
    end else begin
      next_ptr_s = owner_r + PTR_W'(1);
    end
    win_delay_s = DELAY_W'(delay_in >> (int'(win_idx_s) * DELAY_W));
  end

  // Timer FSM; abort is tested before expiry so it wins in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ptr_r   <= {PTR_W{1'b0}};
      owner_r <= {PTR_W{1'b0}};
      grant   <= {NUM_REQ{1'b0}};
      done    <= {NUM_REQ{1'b0}};
      busy    <= 1'b0;
      count   <= {DELAY_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= {NUM_REQ{1'b0}};
          if (win_valid_s) begin
            grant   <= win_onehot_s;
            owner_r <= win_idx_s;
            count   <= win_delay_s;
            busy    <= 1'b1;
            state_r <= COUNT;
          end else begin
            grant   <= {NUM_REQ{1'b0}};
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        COUNT: begin
          if (!owner_req_s) begin
            grant   <= {NUM_REQ{1'b0}};
            done    <= {NUM_REQ{1'b0}};
            count   <= {DELAY_W{1'b0}};
            busy    <= 1'b0;
            ptr_r   <= next_ptr_s;
            state_r <= IDLE;
          end else if (count == {DELAY_W{1'b0}}) begin
            done    <= grant;
            grant   <= {NUM_REQ{1'b0}};
            busy    <= 1'b0;
            ptr_r   <= next_ptr_s;
            state_r <= IDLE;
          end else begin
            count   <= count - DELAY_W'(1);
            done    <= {NUM_REQ{1'b0}};
            state_r <= COUNT;
          end
        end
        default: begin
          state_r <= IDLE;
          grant   <= {NUM_REQ{1'b0}};
          done    <= {NUM_REQ{1'b0}};
          busy    <= 1'b0;
          count   <= {DELAY_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed and random bench for delay_timer_arbiter against a remaining-cycles reference model.
module tb_delay_timer_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] delay_in;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = free), grant cycles still to go, search pointer.
  int           m_owner = -1;
  int           m_left  = 0;
  int           m_ptr   = 0;
  logic [N-1:0] m_done  = '0;
  logic [W-1:0] m_count = '0;

  delay_timer_arbiter #(.NUM_REQ(N), .DELAY_W(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .delay_in (delay_in),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_grant();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  function automatic int delay_of(input int idx);
    return int'((delay_in >> (idx * W)) & {{(N*W-W){1'b0}}, {W{1'b1}}});
  endfunction

  task automatic model_reset();
    m_owner = -1; m_left = 0; m_ptr = 0; m_done = '0; m_count = '0;
  endtask

  task automatic model_edge();
    int prev;
    bit found;
    m_done = '0;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && req[idx]) begin
          found   = 1;
          m_owner = idx;
          m_left  = delay_of(idx) + 1;
          m_count = W'(delay_of(idx));
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_count = '0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        prev         = m_owner;
        m_done[prev] = 1'b1;
        m_ptr        = (prev + 1) % N;
        m_owner      = -1;
        m_count      = '0;
      end else begin
        m_count = W'(m_left - 1);
      end
    end
  endtask

  task automatic check_all();
    chk("grant", 32'(grant), 32'(m_grant()));
    chk("done",  32'(done),  32'(m_done));
    chk("busy",  32'(busy),  32'(m_owner >= 0));
    chk("count", 32'(count), 32'(m_count));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  // Asynchronous reset from mid-cycle, then release one edge later.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    req = '0;
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    req      = '0;
    delay_in = '0;
    #2;
    check_all();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycles(2);

    // Single requester, delay 3.
    req = 4'b0010; delay_in[15:8] = 8'd3;
    cycle();
    chk("single_grant", 32'(grant), 32'h2);
    cycles(3);
    chk("single_hold", 32'(grant), 32'h2);
    cycle();
    chk("single_done", 32'(done), 32'h2);
    chk("single_busy_low", 32'(busy), 32'h0);
    req = '0;
    cycles(2);

    // Simultaneous requests after reset: 0 (delay 2) then 2 (delay 5).
    do_reset();
    req = 4'b0101; delay_in = '0; delay_in[7:0] = 8'd2; delay_in[23:16] = 8'd5;
    cycle();
    chk("simul_first", 32'(grant), 32'h1);
    cycles(3);
    chk("simul_done0", 32'(done), 32'h1);
    cycle();
    chk("simul_second", 32'(grant), 32'h4);
    cycles(6);
    chk("simul_done2", 32'(done), 32'h4);
    req = '0;
    cycles(2);

    // Zero delay on requester 3.
    req = 4'b1000; delay_in[31:24] = 8'd0;
    cycle();
    chk("zero_grant", 32'(grant), 32'h8);
    chk("zero_count", 32'(count), 32'h0);
    cycle();
    chk("zero_done", 32'(done), 32'h8);
    req = '0;
    cycles(2);

    // Abort requester 2 after 4 grant cycles; pending 0 then wins.
    req = 4'b0100; delay_in[23:16] = 8'd10;
    cycle();
    req[0] = 1'b1; delay_in[7:0] = 8'd1;
    cycles(3);
    req[2] = 1'b0;
    cycle();
    chk("abort_clear", 32'(grant), 32'h0);
    chk("abort_no_done", 32'(done), 32'h0);
    cycle();
    chk("abort_next", 32'(grant), 32'h1);
    req = '0;
    cycles(3);

    // Long delay interrupted by reset.
    req = 4'b0010; delay_in[15:8] = 8'd200;
    cycles(50);
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    cycles(5);

    // Fairness: all requesting with delay 1.
    do_reset();
    delay_in = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      cycle();
      chk("fair_order", 32'(grant), 32'(4'b0001 << (g % N)));
      cycles(2);
      chk("fair_done", 32'(done), 32'(4'b0001 << (g % N)));
    end
    req = '0;
    cycles(2);

    // Random traffic with delays changing every cycle.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if (done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      delay_in = $urandom() & 32'h0707_0707;
      if (c == 300) do_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
